// File: rtl/music_score_player.sv
// music_score_player
//   Plays a melody stored in an external synchronous score ROM on a passive
//   buzzer. Each ROM word is {note code[15:8], beat count[7:0]}. The note code
//   goes to the music_hz lookup, which returns the tone period in clocks on
//   `cycle`. The player produces a 50%-duty square wave at that period for
//   beats*BEAT_CYC clocks, then a silent gap of GAP_CYC clocks, then the next
//   entry. A zero beat count, or finishing the last ROM address, ends the score.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : one-cycle pulse, begin playback at address 0 (ignored while busy)
//   stop        : one-cycle pulse, abort playback (wins over start)
//   loop_en     : at end of score restart at address 0 instead of finishing
//   rom_addr    : score ROM address (ROM data valid one clock later)
//   rom_data    : {note code, beat count}
//   hz_sel      : note code to music_hz (0 outside PLAY)
//   cycle       : tone period from music_hz, 0 = silence
//   buzzer      : square-wave drive
//   busy        : high in every state except IDLE
//   done        : one-cycle pulse on normal completion
//   state_dbg   : current FSM state, for checkers
//
// Handshake: there is no valid/ready pair here. start and stop are single-cycle
// request pulses sampled on the rising clock edge; done is a single-cycle
// completion pulse. All outputs are registered.
//
// Parameter limits: 1 <= BEAT_CYC < 2**24, 1 <= GAP_CYC < 2**24.

module music_score_player #(
    parameter int ADDR_W   = 8,
    parameter int BEAT_CYC = 6250000,
    parameter int GAP_CYC  = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [7:0]        hz_sel,
    input  logic [19:0]       cycle,
    output logic              buzzer,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [23:0]       BEAT_LAST = 24'(BEAT_CYC - 1);
    localparam logic [23:0]       GAP_LAST  = 24'(GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t      state;
    logic [23:0] beat_cnt;
    logic [23:0] gap_cnt;
    logic [7:0]  beats_left;
    logic [19:0] tone_cnt;

    logic [19:0] half_cycle;
    logic        tone_wrap;
    logic        tone_high;

    // Odd periods get floor(cycle/2) high clocks because of the shift.
    assign half_cycle = cycle >> 1;
    // With cycle == 0 the compare is against 0xFFFFF and the counter simply
    // free-runs; the buzzer is forced low for that case anyway.
    assign tone_wrap  = (tone_cnt >= (cycle - 20'd1));
    assign tone_high  = (cycle != 20'd0) && (tone_cnt < half_cycle);

    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rom_addr   <= '0;
            hz_sel     <= 8'd0;
            buzzer     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            beat_cnt   <= 24'd0;
            gap_cnt    <= 24'd0;
            beats_left <= 8'd0;
            tone_cnt   <= 20'd0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && stop) begin
                // Abort: silent, back to address 0, no completion pulse.
                state    <= S_IDLE;
                busy     <= 1'b0;
                hz_sel   <= 8'd0;
                buzzer   <= 1'b0;
                rom_addr <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        rom_addr <= '0;
                        hz_sel   <= 8'd0;
                        buzzer   <= 1'b0;
                        if (start && !stop) begin
                            state <= S_FETCH;
                            busy  <= 1'b1;
                        end
                    end

                    S_FETCH: begin
                        // Address has been stable; ROM data is valid next clock.
                        buzzer <= 1'b0;
                        state  <= S_LOAD;
                    end

                    S_LOAD: begin
                        buzzer <= 1'b0;
                        if (rom_data[7:0] == 8'd0) begin
                            // End marker.
                            if (loop_en) begin
                                rom_addr <= '0;
                                state    <= S_FETCH;
                            end else begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            hz_sel     <= rom_data[15:8];
                            beats_left <= rom_data[7:0];
                            beat_cnt   <= 24'd0;
                            tone_cnt   <= 20'd0;
                            state      <= S_PLAY;
                        end
                    end

                    S_PLAY: begin
                        buzzer   <= tone_high;
                        tone_cnt <= tone_wrap ? 20'd0 : tone_cnt + 20'd1;
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt   <= 24'd0;
                            beats_left <= beats_left - 8'd1;
                            if (beats_left == 8'd1) begin
                                // Last clock of the final beat.
                                hz_sel  <= 8'd0;
                                gap_cnt <= 24'd0;
                                state   <= S_GAP;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 24'd1;
                        end
                    end

                    S_GAP: begin
                        buzzer <= 1'b0;
                        hz_sel <= 8'd0;
                        if (gap_cnt == GAP_LAST) begin
                            if (rom_addr == ADDR_LAST) begin
                                // Ran off the end of the ROM: same as an end marker.
                                if (loop_en) begin
                                    rom_addr <= '0;
                                    state    <= S_FETCH;
                                end else begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                rom_addr <= rom_addr + 1'b1;
                                state    <= S_FETCH;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 24'd1;
                        end
                    end

                    S_DONE: begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        rom_addr <= '0;
                    end

                    default: begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        hz_sel   <= 8'd0;
                        buzzer   <= 1'b0;
                        rom_addr <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_music_score_player.sv
// Bench for music_score_player with a 4-entry score ROM (ADDR_W=2),
// BEAT_CYC=20, GAP_CYC=4 and a small music_hz lookup model.
// Each observed sample is {busy, done, hz_sel, buzzer, rom_addr}, taken on the
// falling edge, and compared with a per-clock expectation built from the score.

module tb_music_score_player;

    localparam int ADDR_W = 2;
    localparam int BEAT   = 20;
    localparam int GAPC   = 4;
    localparam int W      = 1 + 1 + 8 + 1 + ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [7:0]        hz_sel;
    logic [19:0]       cycle;
    logic              buzzer;
    logic              busy;
    logic              done;
    logic [2:0]        state_dbg;

    logic [15:0]  rom [4];
    logic [7:0]   code_tab [6] = '{8'h06, 8'h07, 8'h08, 8'h09, 8'h00, 8'h55};
    logic [W-1:0] exp_q [$];
    int           loop_clear_idx;
    int           total;
    int           bad;

    music_score_player #(
        .ADDR_W   (ADDR_W),
        .BEAT_CYC (BEAT),
        .GAP_CYC  (GAPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .hz_sel    (hz_sel),
        .cycle     (cycle),
        .buzzer    (buzzer),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    function automatic logic [19:0] hz_of(input logic [7:0] c);
        case (c)
            8'h06:   return 20'd8;
            8'h07:   return 20'd7;
            8'h08:   return 20'd5;
            8'h09:   return 20'd1;
            default: return 20'd0;
        endcase
    endfunction

    always_comb cycle = hz_of(hz_sel);

    initial rom_data = 16'h0000;
    always @(posedge clk) rom_data <= rom[rom_addr];

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] pk(input bit b, input bit d, input logic [7:0] h,
                                        input bit z, input int a);
        logic [ADDR_W-1:0] aa;
        aa = ADDR_W'(a);
        return {b, d, h, z, aa};
    endfunction

    // Square wave level j clocks into a note of period cyc.
    function automatic bit tone(input int j, input int cyc);
        if (cyc == 0) return 1'b0;
        return (j % cyc) < (cyc / 2);
    endfunction

    // Expected sample after each clock edge, starting with the edge that
    // samples start. n_loops = number of end-of-score events that loop.
    task automatic build_model(input int n_loops);
        int a;
        int loops;
        bit fin;
        bit end_score;
        logic [7:0] code;
        int beats;
        int n;
        int cyc;
        a = 0;
        loops = 0;
        fin = 1'b0;
        exp_q.delete();
        loop_clear_idx = -1;
        while (!fin) begin
            exp_q.push_back(pk(1, 0, 8'h00, 0, a));  // fetch
            exp_q.push_back(pk(1, 0, 8'h00, 0, a));  // load
            code = rom[a][15:8];
            beats = int'(rom[a][7:0]);
            end_score = 1'b0;
            if (beats == 0) begin
                end_score = 1'b1;
            end else begin
                n = beats * BEAT;
                cyc = int'(hz_of(code));
                exp_q.push_back(pk(1, 0, code, 0, a));
                for (int j = 0; j < n - 1; j++) exp_q.push_back(pk(1, 0, code, tone(j, cyc), a));
                exp_q.push_back(pk(1, 0, 8'h00, tone(n - 1, cyc), a));
                for (int g = 1; g < GAPC; g++) exp_q.push_back(pk(1, 0, 8'h00, 0, a));
                if (a == (1 << ADDR_W) - 1) end_score = 1'b1;
                else a = a + 1;
            end
            if (end_score) begin
                if (loops < n_loops) begin
                    loops = loops + 1;
                    a = 0;
                    if (loops == n_loops) loop_clear_idx = exp_q.size();
                end else begin
                    exp_q.push_back(pk(1, 1, 8'h00, 0, a));  // completion pulse
                    exp_q.push_back(pk(0, 0, 8'h00, 0, 0));
                    fin = 1'b1;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        assert (act === expv) else begin
            bad++;
            $error("FAIL %s observed={b,d,hz,bz,a}=%h expected=%h", tag, act, expv);
        end
    endtask

    function automatic logic [W-1:0] observed();
        return {busy, done, hz_sel, buzzer, rom_addr};
    endfunction

    // ---------------- driver ----------------
    // Called on a falling edge. stop_at / extra_start_at are sample indices
    // after which a stop pulse or a (should-be-ignored) start pulse is driven.
    task automatic run_score(input string name, input int n_loops, input int stop_at,
                             input int extra_start_at);
        logic [W-1:0] e;
        int n;
        build_model(n_loops);
        if (stop_at >= 0) begin
            while (exp_q.size() > stop_at + 1) exp_q.delete(exp_q.size() - 1);
            exp_q.push_back(pk(0, 0, 8'h00, 0, 0));
        end
        repeat (3) exp_q.push_back(pk(0, 0, 8'h00, 0, 0));
        loop_en = (n_loops > 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", name, n), observed(), e);
            stop  = (n == stop_at);
            start = (n == extra_start_at);
            if (n == loop_clear_idx) loop_en = 1'b0;
            n++;
            @(negedge clk);
        end
        stop = 1'b0;
        start = 1'b0;
        loop_en = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] bts;
        int stop_at;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        loop_en = 1'b0;
        for (int i = 0; i < 4; i++) rom[i] = 16'h0000;

        repeat (2) @(negedge clk);
        check("reset_state", observed(), '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", observed(), '0);

        // Single note, two beats of period 8.
        rom[0] = 16'h0602; rom[1] = 16'h0000;
        run_score("single", 0, -1, -1);

        // Rest then one beat of tone.
        rom[0] = 16'h0003; rom[1] = 16'h0601; rom[2] = 16'h0000;
        run_score("rest", 0, -1, -1);

        // Loop twice over the single-note score, then finish.
        rom[0] = 16'h0602; rom[1] = 16'h0000;
        run_score("loop", 2, -1, -1);

        // Stop at PLAY clock 10 (first PLAY sample is index 2).
        run_score("stop", 0, 12, -1);

        // start while busy is ignored.
        run_score("busy_start", 0, -1, 20);

        // start and stop together in IDLE: stays idle.
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("start_stop_idle[%0d]", i), observed(), '0);
            @(negedge clk);
        end

        // Address wrap: four notes, then done; then with looping.
        for (int i = 0; i < 4; i++) rom[i] = 16'h0601;
        run_score("wrap", 0, -1, -1);
        run_score("wrap_loop", 1, -1, -1);

        // Odd periods, period 1 and unknown codes.
        rom[0] = 16'h0701; rom[1] = 16'h0801; rom[2] = 16'h0901; rom[3] = 16'h5501;
        run_score("odd", 0, -1, -1);

        // Asynchronous reset in the middle of a note.
        rom[0] = 16'h0602; rom[1] = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check("reset_mid_play", observed(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("after_reset[%0d]", i), observed(), '0);
        end
        @(negedge clk);

        // Randomized scores.
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) < 2) bts = 8'd0;
                else bts = 8'($urandom_range(1, 3));
                rom[i] = {code_tab[$urandom_range(0, 5)], bts};
            end
            if ($urandom_range(0, 3) == 0) stop_at = int'($urandom_range(0, 60));
            else stop_at = -1;
            run_score($sformatf("rnd%0d", k), int'($urandom_range(0, 1)), stop_at, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/music_score_player.md
Name: music_score_player

Overview:
- Sequencer that plays a stored melody on the passive buzzer.
- Steps through an external score ROM of {note code, duration} entries and drives the note code to the note-to-period lookup (music_hz), which returns the tone period in clocks.
- Generates the 50%-duty square wave at that period, times each note in beat units, and inserts a silent articulation gap between notes.
- Sits between the user start/stop controls and the buzzer pin.

Parameters:
- ADDR_W, 8: score ROM address width.
- BEAT_CYC, 6250000: clocks per beat unit (125 ms at 50 MHz); must satisfy 1 ≤ BEAT_CYC < 2^24.
- GAP_CYC, 500000: silent clocks after each note (10 ms at 50 MHz); must satisfy 1 ≤ GAP_CYC < 2^24.

Ports:
- clk in 1: system clock.
- rst_n in 1: asynchronous active-low reset.
- start in 1: one-cycle pulse; begin playback from address 0.
- stop in 1: one-cycle pulse; abort playback.
- loop_en in 1: at end of score, restart at address 0 instead of finishing.
- rom_addr out ADDR_W: score ROM address; synchronous ROM, data valid one clock after the address.
- rom_data in 16: [15:8] note code, [7:0] beat count.
- hz_sel out 8: note code to music_hz.
- cycle in 20: tone period from music_hz; 0 means silence.
- buzzer out 1: square-wave drive.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle pulse on normal completion.

Behaviour:
- Reset: all outputs 0 and state IDLE; counters 0 and rom_addr 0. Reset is asynchronous and takes effect mid-operation with no completion pulse.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE. All outputs are registered.
- IDLE:
  - rom_addr=0, hz_sel=0, buzzer=0.
  - start → FETCH.
  - start while busy is ignored.
- FETCH: one cycle; rom_addr stable → LOAD.
- LOAD: samples rom_data.
  - End of score is beats==0, or beats≠0 at rom_addr==2^ADDR_W-1 after that note's GAP (see GAP).
  - beats==0: if loop_en then rom_addr←0 → FETCH; else → DONE.
  - Otherwise: hz_sel←note code, beats_left←beats, beat_cnt←0, tone_cnt←0 → PLAY.
- PLAY: lasts exactly beats×BEAT_CYC clocks.
  - beat_cnt counts 0..BEAT_CYC-1; on wrap, beats_left decrements.
  - Leave after the last clock of the final beat → GAP.
  - Tone counter: tone_cnt increments each clock and resets to 0 when tone_cnt ≥ cycle-1.
  - buzzer←(cycle≠0) && (tone_cnt < cycle>>1).
  - Odd periods give high = floor(cycle/2) clocks.
  - Note code 0 or unknown code (cycle=0) is a rest: buzzer held 0 while duration is still counted.
- GAP: hz_sel←0, buzzer←0 for GAP_CYC clocks.
  - If rom_addr==2^ADDR_W-1: treated as end of score, follows the beats==0 rules (loop to 0 or DONE).
  - Otherwise rom_addr←rom_addr+1 → FETCH.
- DONE: done=1 for one clock, busy=1 → IDLE.
- stop: sampled in any non-IDLE state; next state IDLE with hz_sel=0, buzzer=0, rom_addr=0, no done. stop has priority over start in the same cycle.
- loop_en is sampled only at the end-of-score decision.
- Latency:
  - start at edge T: FETCH at T+1, LOAD at T+2, first PLAY cycle at T+3 with hz_sel valid.
  - First buzzer high at T+4 (registered).
- cycle is assumed combinational from hz_sel and settles within the LOAD→PLAY cycle.

Test Plan (BEAT_CYC=20, GAP_CYC=4, ROM model; music_hz model returns cycle=8 for 8'h06, 0 for 8'h00):
- Reset: assert rst_n=0 mid-PLAY → buzzer, hz_sel, busy, done, rom_addr all 0 immediately; release → IDLE, no done.
- Single note: ROM[0]=16'h0602, ROM[1]=16'h0000, pulse start → hz_sel=8'h06 for 40 clocks, buzzer 4 high/4 low repeated 5 times, 4 gap clocks low, rom_addr=1, done pulse once, busy falls.
- Rest: ROM[0]=16'h0003, ROM[1]=16'h0601, ROM[2]=0 → buzzer 0 for 60+4 clocks, then 20 clocks of tone; total busy duration checked exactly.
- Loop: loop_en=1 on the single-note score → rom_addr returns to 0 after end marker with no done; clear loop_en → the next pass ends with a done pulse.
- Stop/priority: stop at PLAY clock 10 → IDLE next cycle, buzzer 0, no done. start+stop in the same IDLE cycle → stays IDLE. start while busy → ignored.
- Wrap: ADDR_W=2, all four entries 16'h0601 → plays four notes, then done (no fifth fetch); with loop_en=1 → rom_addr wraps 3→0.
